// File: rtl/amo_bus_master_pkg.sv
// Shared atomic-bus definitions: LR/SC funct5 codes, initiator state encoding
// and request-decoding helpers used by amo_bus_master.
package amo_bus_master_pkg;

  localparam logic [4:0] FUNCT5_LR = 5'b00010;
  localparam logic [4:0] FUNCT5_SC = 5'b00011;

  localparam logic [3:0] BYTE_EN_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } bus_state_t;

  // LR is the only atomic that does not write; SC and every AMO do.
  function automatic logic req_wr_en(input logic       atomic,
                                     input logic       wr,
                                     input logic [6:0] operation);
    if (atomic) begin
      return (operation[6:2] != FUNCT5_LR);
    end
    return wr;
  endfunction

  function automatic logic req_misaligned(input logic        atomic,
                                          input logic [31:0] addr);
    return atomic && (addr[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] req_byte_en(input logic       atomic,
                                             input logic [3:0] byte_en);
    return atomic ? BYTE_EN_WORD : byte_en;
  endfunction

endpackage

// File: rtl/amo_bus_master_bus_watchdog.sv
// Cycle counter that flags a hung bus transaction; expires on the
// TIMEOUT_CYCLES-th enabled cycle after clear. TIMEOUT_CYCLES=0 disables it.
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_active
      localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

      logic [CNT_W-1:0] r_count;

      always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
          r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
          r_count <= r_count + 1'b1;
        end
      end

      assign o_expire = i_enable && (r_count == LAST);
    end else begin : g_disabled
      logic w_unused;
      assign w_unused = ^{i_clk, i_rst, i_clear, i_enable};
      assign o_expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/amo_bus_master.sv
// Per-hart initiator for the atomic-capable data bus: registers one
// load/store/LR/SC/AMO request, holds it until ack and returns the result.
module amo_bus_master
  import amo_bus_master_pkg::*;
#(
  parameter int unsigned N_IDS          = 1,
  parameter int unsigned HART_ID        = 0,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic        i_atomic,
  input  logic [6:0]  i_operation,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_byte_en,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rd_data,
  output logic        o_misaligned,
  output logic        o_timeout,
  output logic        o_bus_en,
  output logic        o_wr_en,
  output logic        o_atomic,
  output logic [31:0] o_wr_data,
  output logic [31:0] o_addr,
  output logic [3:0]  o_byte_en,
  output logic [6:0]  o_operation,
  output logic [((N_IDS > 1) ? $clog2(N_IDS) : 1)-1:0] o_id,
  input  logic        i_ack,
  input  logic [31:0] i_rd_data
);

  localparam int unsigned ID_W = (N_IDS > 1) ? $clog2(N_IDS) : 1;

  bus_state_t  r_state;
  logic        r_bus_en;
  logic        r_wr_en;
  logic        r_atomic;
  logic [31:0] r_addr;
  logic [31:0] r_wr_data;
  logic [3:0]  r_byte_en;
  logic [6:0]  r_operation;
  logic [31:0] r_rd_data;
  logic        r_done;
  logic        r_misaligned;
  logic        r_timeout;

  logic w_accept;
  logic w_wd_enable;
  logic w_wd_expire;

  assign w_accept    = (r_state == ST_IDLE) && i_req;
  assign w_wd_enable = (r_state == ST_BUSY) && !i_ack;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_accept),
    .i_enable(w_wd_enable),
    .o_expire(w_wd_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_bus_en     <= 1'b0;
      r_wr_en      <= 1'b0;
      r_atomic     <= 1'b0;
      r_addr       <= '0;
      r_wr_data    <= '0;
      r_byte_en    <= '0;
      r_operation  <= '0;
      r_rd_data    <= '0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses; only the RESP entry sets them.
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            if (req_misaligned(i_atomic, i_addr)) begin
              r_state      <= ST_RESP;
              r_done       <= 1'b1;
              r_misaligned <= 1'b1;
            end else begin
              r_state     <= ST_BUSY;
              r_bus_en    <= 1'b1;
              r_wr_en     <= req_wr_en(i_atomic, i_wr, i_operation);
              r_atomic    <= i_atomic;
              r_addr      <= i_addr;
              r_wr_data   <= i_wr_data;
              r_byte_en   <= req_byte_en(i_atomic, i_byte_en);
              r_operation <= i_operation;
            end
          end
        end

        ST_BUSY: begin
          // Ack in the expiry cycle takes priority over the watchdog.
          if (i_ack) begin
            r_state   <= ST_RESP;
            r_bus_en  <= 1'b0;
            r_rd_data <= i_rd_data;
            r_done    <= 1'b1;
          end else if (w_wd_expire) begin
            r_state   <= ST_RESP;
            r_bus_en  <= 1'b0;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
          end
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state  <= ST_IDLE;
          r_bus_en <= 1'b0;
        end
      endcase
    end
  end

  // The controller re-samples o_bus_en during the ack cycle, so drop it there.
  assign o_bus_en     = r_bus_en && !i_ack;
  assign o_stall      = i_req && !r_done;
  assign o_done       = r_done;
  assign o_rd_data    = r_rd_data;
  assign o_misaligned = r_misaligned;
  assign o_timeout    = r_timeout;
  assign o_wr_en      = r_wr_en;
  assign o_atomic     = r_atomic;
  assign o_wr_data    = r_wr_data;
  assign o_addr       = r_addr;
  assign o_byte_en    = r_byte_en;
  assign o_operation  = r_operation;
  assign o_id         = ID_W'(HART_ID);

endmodule

// File: tb/tb_amo_bus_master.sv
// Directed bench for amo_bus_master: plain load, LR/SC, misaligned AMO,
// watchdog expiry and ack-wins, back-to-back requests and mid-BUSY reset.
module tb_amo_bus_master;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req;
  logic        i_wr;
  logic        i_atomic;
  logic [6:0]  i_operation;
  logic [31:0] i_addr;
  logic [31:0] i_wr_data;
  logic [3:0]  i_byte_en;
  logic        o_stall;
  logic        o_done;
  logic [31:0] o_rd_data;
  logic        o_misaligned;
  logic        o_timeout;
  logic        o_bus_en;
  logic        o_wr_en;
  logic        o_atomic;
  logic [31:0] o_wr_data;
  logic [31:0] o_addr;
  logic [3:0]  o_byte_en;
  logic [6:0]  o_operation;
  logic [1:0]  o_id;
  logic        i_ack;
  logic [31:0] i_rd_data;

  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic [6:0] OP_LR     = 7'h08;
  localparam logic [6:0] OP_SC     = 7'h0C;
  localparam logic [6:0] OP_AMOADD = 7'h00;

  amo_bus_master #(
    .N_IDS         (4),
    .HART_ID       (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_wr        (i_wr),
    .i_atomic    (i_atomic),
    .i_operation (i_operation),
    .i_addr      (i_addr),
    .i_wr_data   (i_wr_data),
    .i_byte_en   (i_byte_en),
    .o_stall     (o_stall),
    .o_done      (o_done),
    .o_rd_data   (o_rd_data),
    .o_misaligned(o_misaligned),
    .o_timeout   (o_timeout),
    .o_bus_en    (o_bus_en),
    .o_wr_en     (o_wr_en),
    .o_atomic    (o_atomic),
    .o_wr_data   (o_wr_data),
    .o_addr      (o_addr),
    .o_byte_en   (o_byte_en),
    .o_operation (o_operation),
    .o_id        (o_id),
    .i_ack       (i_ack),
    .i_rd_data   (i_rd_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance into the next cycle; inputs are driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic set_req(input logic wr, input logic atomic, input logic [6:0] op,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be);
    i_req       = 1'b1;
    i_wr        = wr;
    i_atomic    = atomic;
    i_operation = op;
    i_addr      = addr;
    i_wr_data   = data;
    i_byte_en   = be;
    #1;
  endtask

  task automatic set_ack(input logic [31:0] data);
    i_ack     = 1'b1;
    i_rd_data = data;
    #1;
  endtask

  task automatic clr_ack();
    i_ack     = 1'b0;
    i_rd_data = '0;
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_req = 1'b0; i_wr = 1'b0; i_atomic = 1'b0; i_operation = '0;
    i_addr = '0; i_wr_data = '0; i_byte_en = '0; i_ack = 1'b0; i_rd_data = '0;
    tick(); tick();
    check("rst_done", o_done, 0);
    check("rst_bus_en", o_bus_en, 0);
    check("rst_rd_data", o_rd_data, 0);
    check("rst_addr", o_addr, 0);
    check("rst_id", 32'(o_id), 2);
    i_rst = 1'b0;
    tick();

    // Plain load, ack on the 3rd BUSY cycle; i_req drops and i_addr changes mid-BUSY.
    set_req(1'b0, 1'b0, 7'h00, 32'h100, 32'h0, 4'h3);
    check("ld_c0_bus_en", o_bus_en, 0);
    check("ld_c0_stall", o_stall, 1);
    tick();
    check("ld_c1_bus_en", o_bus_en, 1);
    check("ld_c1_addr", o_addr, 32'h100);
    check("ld_c1_wr_en", o_wr_en, 0);
    check("ld_c1_byte_en", o_byte_en, 4'h3);
    check("ld_c1_atomic", o_atomic, 0);
    tick();
    check("ld_c2_bus_en", o_bus_en, 1);
    i_req = 1'b0; i_addr = 32'h999; #1;
    tick();
    check("ld_c3_bus_en_pre_ack", o_bus_en, 1);
    check("ld_c3_addr_held", o_addr, 32'h100);
    set_ack(32'hDEADBEEF);
    check("ld_c3_bus_en_ack", o_bus_en, 0);
    check("ld_c3_done", o_done, 0);
    tick();
    clr_ack();
    check("ld_c4_done", o_done, 1);
    check("ld_c4_rd_data", o_rd_data, 32'hDEADBEEF);
    check("ld_c4_timeout", o_timeout, 0);
    check("ld_c4_misaligned", o_misaligned, 0);
    tick();
    check("ld_c5_done", o_done, 0);
    check("ld_c5_bus_en", o_bus_en, 0);

    // LR to 0x40 then SC of 0x5 to 0x40; controller reports success (0).
    set_req(1'b1, 1'b1, OP_LR, 32'h40, 32'h0, 4'h1);
    tick();
    check("lr_bus_en", o_bus_en, 1);
    check("lr_wr_en", o_wr_en, 0);
    check("lr_atomic", o_atomic, 1);
    check("lr_byte_en", o_byte_en, 4'hF);
    check("lr_op", o_operation, OP_LR);
    set_ack(32'h12345678);
    tick();
    clr_ack();
    check("lr_done", o_done, 1);
    check("lr_rd_data", o_rd_data, 32'h12345678);
    i_req = 1'b0;
    tick();
    set_req(1'b0, 1'b1, OP_SC, 32'h40, 32'h5, 4'h2);
    tick();
    check("sc_bus_en", o_bus_en, 1);
    check("sc_wr_en", o_wr_en, 1);
    check("sc_byte_en", o_byte_en, 4'hF);
    check("sc_wr_data", o_wr_data, 32'h5);
    check("sc_addr", o_addr, 32'h40);
    set_ack(32'h0);
    tick();
    clr_ack();
    check("sc_done", o_done, 1);
    check("sc_rd_data", o_rd_data, 32'h0);
    i_req = 1'b0;
    tick();

    // Misaligned AMOADD at 0x42: completes in cycle 1 without bus access.
    set_req(1'b0, 1'b1, OP_AMOADD, 32'h42, 32'h9, 4'h0);
    check("mis_c0_bus_en", o_bus_en, 0);
    tick();
    check("mis_c1_done", o_done, 1);
    check("mis_c1_misaligned", o_misaligned, 1);
    check("mis_c1_bus_en", o_bus_en, 0);
    check("mis_c1_rd_data", o_rd_data, 32'h0);
    i_req = 1'b0;
    tick();
    check("mis_c2_done", o_done, 0);
    check("mis_c2_misaligned", o_misaligned, 0);
    check("mis_c2_bus_en", o_bus_en, 0);
    tick();

    // No ack: bus_en high cycles 1..8, timeout completion in cycle 9.
    set_req(1'b0, 1'b0, 7'h00, 32'h200, 32'h0, 4'hF);
    for (int unsigned c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("to_c%0d_bus_en", c), o_bus_en, 1);
      check($sformatf("to_c%0d_done", c), o_done, 0);
    end
    tick();
    check("to_c9_done", o_done, 1);
    check("to_c9_timeout", o_timeout, 1);
    check("to_c9_bus_en", o_bus_en, 0);
    check("to_c9_rd_data", o_rd_data, 32'h0);
    i_req = 1'b0;
    tick();
    check("to_c10_timeout", o_timeout, 0);
    check("to_c10_done", o_done, 0);

    // Ack in the expiry cycle (cycle 8) wins.
    set_req(1'b0, 1'b0, 7'h00, 32'h204, 32'h0, 4'hF);
    for (int unsigned c = 1; c <= 7; c++) tick();
    tick();
    check("aw_c8_bus_en_pre_ack", o_bus_en, 1);
    set_ack(32'hCAFEF00D);
    check("aw_c8_bus_en_ack", o_bus_en, 0);
    tick();
    clr_ack();
    check("aw_c9_done", o_done, 1);
    check("aw_c9_timeout", o_timeout, 0);
    check("aw_c9_rd_data", o_rd_data, 32'hCAFEF00D);
    i_req = 1'b0;
    tick();

    // Back-to-back with i_req held: one-cycle IDLE gap, no duplicate request.
    set_req(1'b0, 1'b0, 7'h00, 32'h300, 32'h0, 4'hF);
    tick();
    check("bb_c1_bus_en", o_bus_en, 1);
    set_ack(32'h11);
    tick();
    clr_ack();
    check("bb_c2_done", o_done, 1);
    check("bb_c2_bus_en", o_bus_en, 0);
    check("bb_c2_stall", o_stall, 0);
    i_addr = 32'h304; #1;
    tick();
    check("bb_c3_bus_en", o_bus_en, 0);
    check("bb_c3_done", o_done, 0);
    check("bb_c3_stall", o_stall, 1);
    tick();
    check("bb_c4_bus_en", o_bus_en, 1);
    check("bb_c4_addr", o_addr, 32'h304);
    set_ack(32'h22);
    tick();
    clr_ack();
    check("bb_c5_done", o_done, 1);
    check("bb_c5_rd_data", o_rd_data, 32'h22);
    i_req = 1'b0;
    tick();

    // Reset during BUSY of a store, then a normal load.
    set_req(1'b1, 1'b0, 7'h00, 32'h400, 32'hA5A5, 4'hC);
    tick();
    check("rb_c1_wr_en", o_wr_en, 1);
    check("rb_c1_wr_data", o_wr_data, 32'hA5A5);
    check("rb_c1_byte_en", o_byte_en, 4'hC);
    tick();
    i_rst = 1'b1; i_req = 1'b0; #1;
    tick();
    i_rst = 1'b0; #1;
    check("rb_bus_en", o_bus_en, 0);
    check("rb_wr_en", o_wr_en, 0);
    check("rb_addr", o_addr, 0);
    check("rb_wr_data", o_wr_data, 0);
    check("rb_byte_en", o_byte_en, 0);
    check("rb_rd_data", o_rd_data, 0);
    check("rb_done", o_done, 0);
    check("rb_id", 32'(o_id), 2);
    set_req(1'b0, 1'b0, 7'h00, 32'h500, 32'h0, 4'hF);
    check("rb_accept_bus_en", o_bus_en, 0);
    tick();
    check("rb_post_bus_en", o_bus_en, 1);
    check("rb_post_addr", o_addr, 32'h500);
    set_ack(32'h77);
    tick();
    clr_ack();
    check("rb_post_done", o_done, 1);
    check("rb_post_rd_data", o_rd_data, 32'h77);
    i_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
